// File: rtl/json_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : json_pkg
//  Description : Shared definitions for the streaming JSON pair counter.
//                Parser state encoding, ASCII constants for the structural
//                characters and whitespace set, and the per-character class
//                flag bundle produced by json_char_class.
//  Revision    : 1.0  initial release
// ============================================================================
package json_pkg;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        OBJ_OPEN    = 4'd1,
        KEY_FIRST   = 4'd2,
        KEY         = 4'd3,
        KEY_ESC     = 4'd4,
        AFTER_KEY   = 4'd5,
        VAL_WAIT    = 4'd6,
        VAL_STR     = 4'd7,
        VAL_ESC     = 4'd8,
        VAL_BARE    = 4'd9,
        AFTER_VAL   = 4'd10,
        AFTER_COMMA = 4'd11,
        RESYNC      = 4'd12
    } state_t;

    localparam logic [7:0] LBRACE = 8'h7B;
    localparam logic [7:0] RBRACE = 8'h7D;
    localparam logic [7:0] QUOTE  = 8'h22;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] BSLASH = 8'h5C;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] TAB    = 8'h09;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] CR     = 8'h0D;

    // Exactly one flag is set for any input byte.
    typedef struct packed {
        logic ws;
        logic quote;
        logic bslash;
        logic lbrace;
        logic rbrace;
        logic colon;
        logic comma;
        logic bare;
    } char_class_t;

    function automatic logic is_ws(input logic [7:0] c);
        return (c == SPACE) || (c == TAB) || (c == LF) || (c == CR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/json_char_class.sv
`default_nettype none
// ============================================================================
//  Module      : json_char_class
//  Description : Combinational character classifier. Maps one ASCII byte to
//                one-hot class flags used by the parser FSM.
//  Ports       : char - input byte
//                cls  - one-hot class flags (ws, quote, bslash, lbrace,
//                       rbrace, colon, comma, bare)
//  Revision    : 1.0  initial release
// ============================================================================
module json_char_class
    import json_pkg::*;
(
    input  logic [7:0]  char,
    output char_class_t cls
);

    always_comb begin
        cls        = '0;
        cls.ws     = is_ws(char);
        cls.quote  = (char == QUOTE);
        cls.bslash = (char == BSLASH);
        cls.lbrace = (char == LBRACE);
        cls.rbrace = (char == RBRACE);
        cls.colon  = (char == COLON);
        cls.comma  = (char == COMMA);
        // Backslash is its own class but is still a legal bare-token char.
        cls.bare   = ~(cls.ws | cls.quote | cls.bslash | cls.lbrace |
                       cls.rbrace | cls.colon | cls.comma);
    end

endmodule
`default_nettype wire

// File: rtl/json_pair_counter.sv
`default_nettype none
// ============================================================================
//  Module      : json_pair_counter
//  Description : Streaming JSON object analyser. Consumes one character per
//                cycle with in_valid high and reports the number of top-level
//                key/value pairs of each completed object plus the running
//                maximum. Supports nesting up to MAX_DEPTH, string escapes,
//                bare-token values, saturating counts and error pulses.
//  Ports       : clk      - rising-edge clock
//                reset    - asynchronous active-low reset
//                in_valid - char consumed when high
//                char     - ASCII input byte
//                cur_num  - pair count of last closed object (0 after error)
//                max_num  - maximum cur_num since reset
//                obj_done - one-cycle pulse, top-level object closed
//                err      - one-cycle pulse, grammar violation
//  Revision    : 1.0  initial release
// ============================================================================
module json_pair_counter
    import json_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       char,
    output logic [CNT_W-1:0] cur_num,
    output logic [CNT_W-1:0] max_num,
    output logic             obj_done,
    output logic             err
);

    localparam int             DW        = $clog2(MAX_DEPTH + 1);
    localparam logic [DW-1:0]  DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0]  DEPTH_MAX = DW'(MAX_DEPTH);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    char_class_t       cls;
    state_t            state;
    state_t            state_n;
    logic [DW-1:0]     depth;
    logic [DW-1:0]     depth_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [CNT_W-1:0]  pair_cnt;
    logic              close_req;
    logic              done_req;
    logic              err_req;

    json_char_class u_char_class (
        .char (char),
        .cls  (cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (in_valid) begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        depth_n   = depth;
        cnt_n     = cnt;
        close_req = 1'b0;
        done_req  = 1'b0;
        err_req   = 1'b0;
        // Count after a pair completes; only top-level pairs count.
        pair_cnt  = ((depth == DEPTH_ONE) && (cnt != CNT_SAT)) ? cnt + 1'b1 : cnt;

        case (state)
            IDLE: begin
                if (cls.lbrace) begin
                    state_n = OBJ_OPEN;
                    depth_n = DEPTH_ONE;
                    cnt_n   = '0;
                end
            end
            OBJ_OPEN: begin
                if (cls.quote)       state_n   = KEY_FIRST;
                else if (cls.rbrace) close_req = 1'b1;
                else if (!cls.ws)    err_req   = 1'b1;
            end
            KEY_FIRST: begin
                if (cls.quote)       err_req = 1'b1;
                else if (cls.bslash) state_n = KEY_ESC;
                else                 state_n = KEY;
            end
            KEY: begin
                if (cls.quote)       state_n = AFTER_KEY;
                else if (cls.bslash) state_n = KEY_ESC;
            end
            KEY_ESC: begin
                state_n = KEY;
            end
            AFTER_KEY: begin
                if (cls.colon)    state_n = VAL_WAIT;
                else if (!cls.ws) err_req = 1'b1;
            end
            VAL_WAIT: begin
                if (cls.ws) begin
                    state_n = VAL_WAIT;
                end else if (cls.quote) begin
                    state_n = VAL_STR;
                end else if (cls.lbrace) begin
                    if (depth == DEPTH_MAX) begin
                        err_req = 1'b1;
                    end else begin
                        depth_n = depth + 1'b1;
                        state_n = OBJ_OPEN;
                    end
                end else if (cls.comma || cls.rbrace || cls.colon) begin
                    err_req = 1'b1;
                end else begin
                    state_n = VAL_BARE;
                end
            end
            VAL_STR: begin
                if (cls.quote)       state_n = AFTER_VAL;
                else if (cls.bslash) state_n = VAL_ESC;
            end
            VAL_ESC: begin
                state_n = VAL_STR;
            end
            VAL_BARE: begin
                if (cls.ws) begin
                    state_n = AFTER_VAL;
                end else if (cls.comma) begin
                    cnt_n   = pair_cnt;
                    state_n = AFTER_COMMA;
                end else if (cls.rbrace) begin
                    cnt_n     = pair_cnt;
                    close_req = 1'b1;
                end else if (!(cls.bare || cls.bslash)) begin
                    err_req = 1'b1;
                end
            end
            AFTER_VAL: begin
                if (cls.comma) begin
                    cnt_n   = pair_cnt;
                    state_n = AFTER_COMMA;
                end else if (cls.rbrace) begin
                    cnt_n     = pair_cnt;
                    close_req = 1'b1;
                end else if (!cls.ws) begin
                    err_req = 1'b1;
                end
            end
            AFTER_COMMA: begin
                if (cls.quote)    state_n = KEY_FIRST;
                else if (!cls.ws) err_req = 1'b1;
            end
            RESYNC: begin
                if (cls.rbrace) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A nested close returns to the parent as a completed value.
        if (close_req) begin
            if (depth == DEPTH_ONE) begin
                done_req = 1'b1;
                state_n  = IDLE;
            end else begin
                depth_n = depth - 1'b1;
                state_n = AFTER_VAL;
            end
        end

        // An offending '}' already terminates the object, so skip resync.
        if (err_req) begin
            state_n = cls.rbrace ? IDLE : RESYNC;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            depth    <= '0;
            cnt      <= '0;
            cur_num  <= '0;
            max_num  <= '0;
            obj_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            obj_done <= 1'b0;
            err      <= 1'b0;
            if (in_valid) begin
                depth <= depth_n;
                cnt   <= cnt_n;
                if (done_req) begin
                    cur_num  <= cnt_n;
                    max_num  <= (cnt_n > max_num) ? cnt_n : max_num;
                    obj_done <= 1'b1;
                end
                if (err_req) begin
                    cur_num <= '0;
                    err     <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_json_pair_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_json_pair_counter
//  Description : Self-checking bench for json_pair_counter. Two instances
//                share one character stream: A (CNT_W=8, MAX_DEPTH=3) and
//                B (CNT_W=2, MAX_DEPTH=2). Each table record gives a stream
//                and the single event (done or err, with cur/max) expected
//                from each instance; events are queued before driving and
//                popped by a monitor when a pulse appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_json_pair_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] ch;

    logic [7:0] cur_a, max_a;
    logic       done_a, err_a;
    logic [1:0] cur_b, max_b;
    logic       done_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        bit is_err;
        int cur;
        int mx;
    } ev_t;

    typedef struct {
        string s;
        bit    a_err;
        int    a_cur;
        int    a_max;
        bit    b_err;
        int    b_cur;
        int    b_max;
    } vec_t;

    vec_t vecs[$];
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  ea, eb;

    always #5 clk = ~clk;

    json_pair_counter #(.CNT_W(8), .MAX_DEPTH(3)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .cur_num(cur_a), .max_num(max_a), .obj_done(done_a), .err(err_a)
    );

    json_pair_counter #(.CNT_W(2), .MAX_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .char(ch),
        .cur_num(cur_b), .max_num(max_b), .obj_done(done_b), .err(err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input string s,
                                input bit a_err, input int a_cur, input int a_max,
                                input bit b_err, input int b_cur, input int b_max);
        vec_t v;
        v.s = s;
        v.a_err = a_err; v.a_cur = a_cur; v.a_max = a_max;
        v.b_err = b_err; v.b_cur = b_cur; v.b_max = b_max;
        vecs.push_back(v);
    endfunction

    // Scoreboard side: every pulse must match the oldest queued event.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (done_a || err_a) begin
                if (qa.size() == 0) begin
                    check("a_unexpected_event", {30'd0, err_a, done_a}, 0);
                end else begin
                    ea = qa.pop_front();
                    check("a_kind", {30'd0, err_a, done_a}, ea.is_err ? 2 : 1);
                    check("a_cur", cur_a, ea.cur);
                    check("a_max", max_a, ea.mx);
                end
            end
            if (done_b || err_b) begin
                if (qb.size() == 0) begin
                    check("b_unexpected_event", {30'd0, err_b, done_b}, 0);
                end else begin
                    eb = qb.pop_front();
                    check("b_kind", {30'd0, err_b, done_b}, eb.is_err ? 2 : 1);
                    check("b_cur", cur_b, eb.cur);
                    check("b_max", max_b, eb.mx);
                end
            end
        end
    end

    // Idle bytes are '{' so that a DUT ignoring in_valid would visibly misparse.
    task automatic send(input string s, input bit gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ch       = s[i];
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
                ch       = 8'h7B;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        ch       = 8'h7B;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
        check("a_pending_events", qa.size(), 0);
        check("b_pending_events", qb.size(), 0);
        qa.delete();
        qb.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_cur_a"},  cur_a,  0);
        check({tag, "_max_a"},  max_a,  0);
        check({tag, "_done_a"}, done_a, 0);
        check({tag, "_err_a"},  err_a,  0);
        check({tag, "_cur_b"},  cur_b,  0);
        check({tag, "_max_b"},  max_b,  0);
        check({tag, "_done_b"}, done_b, 0);
        check({tag, "_err_b"},  err_b,  0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero(tag);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_table(input bit gap);
        ev_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            e.is_err = vecs[i].a_err; e.cur = vecs[i].a_cur; e.mx = vecs[i].a_max;
            qa.push_back(e);
            e.is_err = vecs[i].b_err; e.cur = vecs[i].b_cur; e.mx = vecs[i].b_max;
            qb.push_back(e);
            send(vecs[i].s, gap);
            settle();
        end
    endtask

    initial begin
        ev_t e;
        reset    = 1'b0;
        in_valid = 1'b0;
        ch       = 8'h7B;

        //    stream                                        A: err cur max    B: err cur max
        add("{}",                                           0, 0, 0,          0, 0, 0);
        add("{\"k\":true}",                                 0, 1, 1,          0, 1, 1);
        add("{\"a\":\"1\", \"b\":2}",                       0, 2, 2,          0, 2, 2);
        add("{\"a\":{\"x\":1,\"y\":{\"z\":2}},\"b\":3}",    0, 2, 2,          1, 0, 2);
        add("{\"\":1}",                                     1, 0, 2,          1, 0, 2);
        add("{\"q\":\"w\"}",                                0, 1, 2,          0, 1, 2);
        add("{\"a\":1,}",                                   1, 0, 2,          1, 0, 2);
        add("{\"k\\\"e\":\"v\\\\\",\"x\":\"}\"}",           0, 2, 2,          0, 2, 2);
        add("{\"\\\"\":1}",                                 0, 1, 2,          0, 1, 2);
        add("{\"a\":1,\"b\":2,\"c\":3,\"d\":4,\"e\":5}",    0, 5, 5,          0, 3, 3);
        add(" \t{ \"p\" :\n\"x y\" ,\015\"z\":{} }",        0, 2, 5,          0, 2, 3);
        add("{\"a\":}",                                     1, 0, 5,          1, 0, 3);
        add("{\"b\":1}",                                    0, 1, 5,          0, 1, 3);
        add("{\"a\":tr\"ue\"}",                             1, 0, 5,          1, 0, 3);
        add("{x}",                                          1, 0, 5,          1, 0, 3);
        add("{\"a\" 1}",                                    1, 0, 5,          1, 0, 3);

        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        run_table(1'b0);

        // Same table with a dead cycle between every char.
        apply_reset("reset2");
        run_table(1'b1);

        // Back-to-back objects: '}{' on consecutive valid cycles.
        e.is_err = 1'b0; e.cur = 1; e.mx = 5; qa.push_back(e);
        e.is_err = 1'b0; e.cur = 2; e.mx = 5; qa.push_back(e);
        e.is_err = 1'b0; e.cur = 1; e.mx = 3; qb.push_back(e);
        e.is_err = 1'b0; e.cur = 2; e.mx = 3; qb.push_back(e);
        send("{\"a\":1}{\"b\":2,\"c\":3}", 1'b0);
        settle();

        // Reset in the middle of an object aborts it silently.
        send("{\"a\":1,\"b\"", 1'b0);
        apply_reset("reset_mid");
        #1;
        check_zero("after_reset_mid");
        e.is_err = 1'b0; e.cur = 1; e.mx = 1; qa.push_back(e);
        e.is_err = 1'b0; e.cur = 1; e.mx = 1; qb.push_back(e);
        send("{\"c\":1}", 1'b0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
